// File: rtl/lifi_sync_pkg.sv
// Shared constants for the LiFi receive synchronizer path: metric width,
// DC threshold, default correlator geometry and accumulator sizing.
package lifi_sync_pkg;

  localparam int METRIC_W = 32;
  localparam logic [METRIC_W-1:0] DC_THRESHOLD = 32'd900000;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DELAY  = 800;
  localparam int DEF_WIN    = 800;
  localparam int DEF_SHIFT  = 3;
  localparam int DEF_ADDR_W = 10;

  // Full-precision running sum of WIN signed products plus one guard bit.
  function automatic int acc_width(input int data_w, input int win);
    return 2 * data_w + $clog2(win) + 1;
  endfunction

endpackage

// File: rtl/circ_delay.sv
// Circular delay line: one write per enable, registered read of the slot
// about to be overwritten, so rd_data is the value written DEPTH writes ago.
module circ_delay #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 800,
  parameter int ADDR_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst || clear)
      ptr <= '0;
    else if (wr_en)
      ptr <= (ptr == LAST) ? '0 : ptr + ADDR_W'(1);
  end

  // NOTE: the array and its read register have no reset so they map to block
  // RAM; the consumer masks stale contents using its own fill count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      // NOTE: both updates are non-blocking, so the read sees the old word
      // (read-before-write) even though it targets the address being written.
      rd_data  <= mem[ptr];
      mem[ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/coarse_corr.sv
// Delay-and-correlate timing metric: |sum of x[n-k]*x[n-k-DELAY] over WIN|,
// shifted and saturated to 32 bits, four-stage pipeline, one strobe per sample.
module coarse_corr import lifi_sync_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DELAY  = DEF_DELAY,
  parameter int WIN    = DEF_WIN,
  parameter int SHIFT  = DEF_SHIFT,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic [METRIC_W-1:0] dc_metric_o,
  output logic                dc_metric_valid,
  output logic                primed
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = acc_width(DATA_W, WIN);
  localparam int FILL_W = $clog2(DELAY + WIN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(DELAY + WIN);
  localparam logic [FILL_W-1:0] DELAY_CNT = FILL_W'(DELAY);
  localparam logic [FILL_W-1:0] WIN_CNT   = FILL_W'(WIN);
  localparam logic [FILL_W-1:0] LAST_CNT  = FILL_W'(DELAY + WIN - 1);

  logic                     accept, prod_we;
  logic [FILL_W-1:0]        fill_cnt;
  logic                     v1, v2, v3;
  logic signed [DATA_W-1:0] x1;
  logic                     dly_ok1, win_ok1, win_ok2, last1, last2, last3;
  logic [DATA_W-1:0]        x_old;
  logic signed [DATA_W-1:0] x_old_m;
  logic signed [PROD_W-1:0] prod_new, prod2, prod_old_m;
  logic [PROD_W-1:0]        prod_old;
  logic signed [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]         abs_acc, shifted;
  logic [METRIC_W-1:0]      metric_sat;

  // A clearing cycle discards the sample presented with it.
  assign accept  = s_valid && !clear && !rst;
  assign prod_we = v1 && !clear && !rst;

  circ_delay #(.WIDTH(DATA_W), .DEPTH(DELAY), .ADDR_W(ADDR_W)) u_sample_line (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .wr_en   (accept),
    .wr_data (s_data),
    .rd_data (x_old)
  );

  assign x_old_m  = dly_ok1 ? signed'(x_old) : '0;
  assign prod_new = PROD_W'(x1) * PROD_W'(x_old_m);

  circ_delay #(.WIDTH(PROD_W), .DEPTH(WIN), .ADDR_W(ADDR_W)) u_prod_line (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .wr_en   (prod_we),
    .wr_data (prod_new),
    .rd_data (prod_old)
  );

  assign prod_old_m = win_ok2 ? signed'(prod_old) : '0;
  assign abs_acc    = acc[ACC_W-1] ? -acc : acc;
  assign shifted    = abs_acc >> SHIFT;
  assign metric_sat = (|shifted[ACC_W-1:METRIC_W]) ? '1 : shifted[METRIC_W-1:0];

  // Control state: fill count, stage valids and the running sum.
  // NOTE: all sequential state uses <= so each stage samples the value its
  // predecessor held before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      fill_cnt <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      acc      <= '0;
    end else begin
      if (accept && fill_cnt != FILL_MAX)
        fill_cnt <= fill_cnt + FILL_W'(1);
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
      if (v2)
        acc <= acc + ACC_W'(prod2) - ACC_W'(prod_old_m);
    end
  end

  // Datapath registers are qualified downstream by the valid bits.
  always_ff @(posedge clk) begin
    x1      <= signed'(s_data);
    dly_ok1 <= fill_cnt >= DELAY_CNT;
    win_ok1 <= fill_cnt >= WIN_CNT;
    last1   <= fill_cnt >= LAST_CNT;
    prod2   <= prod_new;
    win_ok2 <= win_ok1;
    last2   <= last1;
    last3   <= last2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dc_metric_o     <= '0;
      dc_metric_valid <= 1'b0;
      primed          <= 1'b0;
    end else if (clear) begin
      dc_metric_valid <= 1'b0;
      primed          <= 1'b0;
    end else begin
      dc_metric_valid <= v3;
      if (v3) begin
        dc_metric_o <= metric_sat;
        if (last3)
          primed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coarse_corr.sv
// Bench for coarse_corr: default instance plus an unshifted instance, both
// checked every cycle against a direct-sum correlation model.
module tb_coarse_corr;

  localparam int DELAY = 800;
  localparam int WIN   = 800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic [31:0] m0, m1;
  logic        v0, v1, p0, p1;

  coarse_corr dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .dc_metric_o     (m0),
    .dc_metric_valid (v0),
    .primed          (p0)
  );

  coarse_corr #(.SHIFT(0)) dut_sat (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .dc_metric_o     (m1),
    .dc_metric_valid (v1),
    .primed          (p1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Model: every accepted sample since reset/clear is kept; P is summed
  // directly from the definition, absent history counting as zero.
  typedef struct {
    int          due;
    logic [31:0] m0;
    logic [31:0] m1;
    bit          prim;
  } exp_t;

  exp_t        q[$];
  int          hist[$];
  int          cyc = 0;
  bit          started = 0;
  bit          ev_exp;
  bit          prim_exp = 0;
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;
  int          dut_strobes = 0;
  longint      p_sum;
  int          n_idx;

  function automatic logic [31:0] metric_of(input longint p, input int shift);
    longint a;
    a = (p < 0) ? -p : p;
    a = a >>> shift;
    if (a > 64'sh00000000FFFFFFFF) return 32'hFFFFFFFF;
    return 32'(a);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      started  = 1;
      q.delete();
      hist.delete();
      prim_exp = 0;
      last0    = '0;
      last1    = '0;
    end else if (clear) begin
      q.delete();
      hist.delete();
      prim_exp = 0;
    end else if (s_valid) begin
      hist.push_back(int'($signed(s_data)));
      n_idx = hist.size() - 1;
      p_sum = 0;
      for (int k = 0; k < WIN; k++)
        if (n_idx - k - DELAY >= 0)
          p_sum += longint'(hist[n_idx - k]) * longint'(hist[n_idx - k - DELAY]);
      q.push_back('{cyc + 3, metric_of(p_sum, 3), metric_of(p_sum, 0),
                    (n_idx + 1 >= DELAY + WIN)});
    end
  end

  always @(negedge clk) begin
    if (started) begin
      ev_exp = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        ev_exp = 1;
        last0  = q[0].m0;
        last1  = q[0].m1;
        if (q[0].prim) prim_exp = 1;
        void'(q.pop_front());
      end
      if (v0) dut_strobes++;
      check("valid", v0, ev_exp);
      check("valid_sat", v1, ev_exp);
      check("metric", m0, last0);
      check("metric_sat", m1, last1);
      check("primed", p0, prim_exp);
      check("primed_sat", p1, prim_exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input int n, input int v, input int gap);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(v);
      step();
      s_valid = 1'b0;
      repeat (gap) step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    step();
    do_reset();
    check("reset_metric", m0, 0);
    check("reset_valid", v0, 0);
    check("reset_primed", p0, 0);
    check("reset_metric_sat", m1, 0);

    // Constant +100 ramp.
    dut_strobes = 0;
    send(800, 100, 0);
    idle(6);
    check("A_warmup_zero", m0, 0);
    send(1, 100, 0);
    idle(6);
    check("A_801_metric", m0, 1250);
    check("A_801_metric_sat", m1, 10000);
    check("A_801_primed", p0, 0);
    send(799, 100, 0);
    idle(6);
    check("A_full_metric", m0, 1000000);
    check("A_full_metric_sat", m1, 8000000);
    check("A_full_primed", p0, 1);
    check("A_strobes", dut_strobes, 1600);

    // Sign flip after clear.
    do_clear();
    idle(2);
    check("B_clear_hold", m0, 1000000);
    check("B_clear_primed", p0, 0);
    dut_strobes = 0;
    send(800, 100, 0);
    send(800, -100, 0);
    idle(6);
    check("B_neg_full", m0, 1000000);
    send(400, -100, 0);
    idle(6);
    check("B_dip_zero", m0, 0);
    send(400, -100, 0);
    idle(6);
    check("B_recovered", m0, 1000000);
    check("B_primed", p0, 1);
    check("B_strobes", dut_strobes, 2400);

    // Full-scale input: saturation.
    do_reset();
    check("C_reset_metric", m0, 0);
    check("C_reset_primed", p0, 0);
    send(801, 32767, 0);
    idle(6);
    check("C_801_metric", m0, 134209536);
    check("C_801_metric_sat", m1, 1073676289);
    send(799, 32767, 0);
    idle(6);
    check("C_sat_metric", m0, 32'hFFFFFFFF);
    check("C_sat_metric_sat", m1, 32'hFFFFFFFF);
    check("C_primed", p0, 1);

    // Valid every third clock.
    do_reset();
    dut_strobes = 0;
    send(1600, 100, 2);
    idle(6);
    check("D_metric", m0, 1000000);
    check("D_primed", p0, 1);
    check("D_strobes", dut_strobes, 1600);

    // Clear with a sample in the same cycle at sample 1200.
    do_reset();
    dut_strobes = 0;
    send(1199, 100, 0);
    clear   = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'd100;
    step();
    clear   = 1'b0;
    s_valid = 1'b0;
    idle(6);
    check("E_hold_metric", m0, 495000);
    check("E_primed", p0, 0);
    check("E_strobes_pre", dut_strobes, 1196);
    dut_strobes = 0;
    send(800, 100, 0);
    idle(6);
    check("E_post_zero", m0, 0);
    check("E_strobes_post", dut_strobes, 800);

    // Reset mid-stream at sample 1700, then full warm-up again.
    do_reset();
    dut_strobes = 0;
    send(1699, 100, 0);
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'd100;
    step();
    rst     = 1'b0;
    s_valid = 1'b0;
    check("F_rst_metric", m0, 0);
    check("F_rst_valid", v0, 0);
    check("F_rst_primed", p0, 0);
    idle(6);
    check("F_strobes_pre", dut_strobes, 1696);
    dut_strobes = 0;
    send(800, 100, 0);
    idle(6);
    check("F_warmup_zero", m0, 0);
    send(800, 100, 0);
    idle(6);
    check("F_metric", m0, 1000000);
    check("F_primed", p0, 1);
    check("F_strobes", dut_strobes, 1600);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
